// File: rtl/alu_reg_ram_pkg.sv
// alu_reg_ram_pkg: shared opcodes, FSM states and status bit positions
package alu_reg_ram_pkg;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_ADDC = 4'd2, OP_AND = 4'd3;
    localparam logic [3:0] OP_OR = 4'd4, OP_XOR = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7;
    localparam logic [3:0] OP_PASS = 4'd8, OP_LDI = 4'd9, OP_LD = 4'd10, OP_ST = 4'd11;
    localparam int S_Z = 0, S_N = 1, S_C = 2, S_V = 3;
    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_e;
    function automatic logic writes_rd(input logic [3:0] op);
        return op <= OP_LD;
    endfunction
endpackage

// File: rtl/alu_reg_ram_core_alu_core.sv
// alu_core: combinational ALU with carry and signed-overflow outputs
module alu_core
    import alu_reg_ram_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    input  logic [3:0]        op_i,
    output logic [DATA_W-1:0] y_o,
    output logic              c_o,
    output logic              v_o
);
    localparam int SH_W = $clog2(DATA_W);
    logic [DATA_W-1:0] bb;
    logic [DATA_W:0]   sum;
    logic [SH_W-1:0]   sh;
    // Subtraction is a + ~b + 1, so carry out doubles as "no borrow"
    always_comb begin
        bb = op_i == OP_SUB ? ~b_i : b_i;
        sum = {1'b0, a_i} + {1'b0, bb} + (DATA_W+1)'(op_i == OP_SUB ? 1'b1 : op_i == OP_ADDC ? cin_i : 1'b0);
        sh = b_i[SH_W-1:0];
        y_o = op_i inside {OP_ADD, OP_SUB, OP_ADDC} ? sum[DATA_W-1:0] :
              op_i == OP_AND  ? a_i & b_i :
              op_i == OP_OR   ? a_i | b_i :
              op_i == OP_XOR  ? a_i ^ b_i :
              op_i == OP_SHL  ? a_i << sh :
              op_i == OP_SHR  ? a_i >> sh :
              op_i == OP_PASS ? a_i :
              op_i == OP_LDI  ? b_i : '0;
        c_o = sum[DATA_W];
        v_o = (a_i[DATA_W-1] == bb[DATA_W-1]) && (sum[DATA_W-1] != a_i[DATA_W-1]);
    end
endmodule

// File: rtl/alu_reg_ram_core.sv
// alu_reg_ram_core: sequenced register-file / ALU / RAM datapath with valid/ready op intake
module alu_reg_ram_core
    import alu_reg_ram_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS = 32,
    parameter int RAM_DEPTH = 256
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     op_valid_i,
    output logic                     op_ready_o,
    input  logic [3:0]               op_code_i,
    input  logic [$clog2(NREGS)-1:0] rd_i,
    input  logic [$clog2(NREGS)-1:0] ra_i,
    input  logic [$clog2(NREGS)-1:0] rb_i,
    input  logic [DATA_W-1:0]        imm_i,
    input  logic                     use_imm_i,
    input  logic                     cin_i,
    output logic                     done_o,
    output logic [DATA_W-1:0]        result_o,
    output logic                     cout_o,
    output logic [3:0]               status_o,
    output logic [DATA_W-1:0]        rd_a_o,
    output logic [DATA_W-1:0]        rd_b_o
);
    localparam int RIDX_W = $clog2(NREGS);
    localparam int ADDR_W = $clog2(RAM_DEPTH);
    state_e              state_q, state_d;
    logic [3:0]          op_q, status_q, status_d;
    logic [RIDX_W-1:0]   rd_q;
    logic [DATA_W-1:0]   imm_q, a_q, b_q, res_q, alu_y, alu_b;
    logic                use_imm_q, cin_q, alu_c, alu_v, is_mem;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   ram_q [RAM_DEPTH];

    assign is_mem = op_q == OP_LD || op_q == OP_ST;
    assign alu_b = (use_imm_q || op_q == OP_LDI) ? imm_q : b_q;
    assign addr = ADDR_W'(a_q + imm_q);
    assign op_ready_o = state_q == IDLE;
    assign done_o = state_q == WB && !reset_i;
    assign result_o = res_q;
    assign status_o = status_q;
    assign cout_o = status_q[S_C];
    assign rd_a_o = a_q;
    assign rd_b_o = b_q;

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .a_i(a_q), .b_i(alu_b), .cin_i(cin_q), .op_i(op_q),
        .y_o(alu_y), .c_o(alu_c), .v_o(alu_v)
    );

    // Arithmetic ops refresh every flag; logic, shift and PASS only N and Z
    always_comb begin
        status_d = status_q;
        status_d[S_V] = op_q <= OP_ADDC ? alu_v : status_q[S_V];
        status_d[S_C] = op_q <= OP_ADDC ? alu_c : status_q[S_C];
        status_d[S_N] = op_q <= OP_PASS ? alu_y[DATA_W-1] : status_q[S_N];
        status_d[S_Z] = op_q <= OP_PASS ? alu_y == '0 : status_q[S_Z];
    end

    // Sequencing: IDLE -> EXEC -> (MEM for LD/ST) -> WB -> IDLE
    always_comb begin
        state_d = state_q;
        state_d = state_q == IDLE ? (op_valid_i ? EXEC : IDLE) :
                  state_q == EXEC ? (is_mem ? MEM : WB) :
                  state_q == MEM  ? WB : IDLE;
    end

    // FSM state register
    always_ff @(posedge clock_i) begin
        state_q <= reset_i ? IDLE : state_d;
    end

    // Operand latch at accept, result/status capture, RAM read and register writeback
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            op_q <= '0;
            rd_q <= '0;
            imm_q <= '0;
            use_imm_q <= 1'b0;
            cin_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            res_q <= '0;
            status_q <= '0;
        end else begin
            if (state_q == IDLE && op_valid_i) begin
                op_q <= op_code_i;
                rd_q <= rd_i;
                imm_q <= imm_i;
                use_imm_q <= use_imm_i;
                cin_q <= cin_i;
                a_q <= regs_q[ra_i];
                b_q <= regs_q[rb_i];
            end
            if (state_q == EXEC) status_q <= status_d;
            if (state_q == EXEC && op_q <= OP_LDI) res_q <= alu_y;
            if (state_q == MEM) res_q <= op_q == OP_LD ? ram_q[addr] : DATA_W'(addr);
            if (state_q == WB && writes_rd(op_q)) regs_q[rd_q] <= res_q;
        end
    end

    // Store lands in MEM even if reset arrives in that cycle; RAM is never cleared
    always_ff @(posedge clock_i) begin
        if (state_q == MEM && op_q == OP_ST) ram_q[addr] <= b_q;
    end
endmodule
